// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front end for the bike-light controller's three user buttons. Each raw,
// asynchronous, bouncy button is synchronized (two flops), debounced, and
// turned into a single-cycle press pulse for the light FSM. faster/slower
// additionally auto-repeat while held. A faster+slower chord is a conflict:
// both of those outputs stay low while the chord lasts.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles before a level flips (>=2)
//   REPEAT_DELAY     cycles after the initial pulse before the first repeat (>=2)
//   REPEAT_PERIOD    cycles between later repeat pulses (>=2)
//   REPEAT_EN        1 = auto-repeat on faster/slower, 0 = one pulse per press
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   raw_next    raw next button (async, active high)
//   raw_faster  raw faster button (async, active high)
//   raw_slower  raw slower button (async, active high)
//   next        one-cycle press pulse
//   faster      one-cycle press / repeat pulse
//   slower      one-cycle press / repeat pulse
//   btn_level   debounced levels {slower, faster, next}
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 32,
   parameter int REPEAT_EN       = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       raw_next,
   input  logic       raw_faster,
   input  logic       raw_slower,
   output logic       next,
   output logic       faster,
   output logic       slower,
   output logic [2:0] btn_level
);

   localparam int MAX_DR   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_TERM = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
   localparam int CNT_W    = $clog2(MAX_TERM + 1);

   // Counters are compared against terminal-1: the edge on which the count
   // "would reach" the terminal value is the edge that acts and clears.
   localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } rep_state_t;

   // Bit order everywhere: [0]=next, [1]=faster, [2]=slower.
   logic [2:0]       raw;
   logic [2:0]       sync_p0;
   logic [2:0]       sync_p1;
   logic [2:0]       level;
   logic [2:0]       level_nxt;
   logic [CNT_W-1:0] db_cnt     [3];
   logic [CNT_W-1:0] db_cnt_nxt [3];

   // Repeat channels: [0]=faster, [1]=slower.
   rep_state_t       rep_state     [2];
   rep_state_t       rep_state_nxt [2];
   logic [CNT_W-1:0] hold_cnt      [2];
   logic [CNT_W-1:0] hold_cnt_nxt  [2];
   logic [1:0]       rep_pulse;

   logic             chord;
   logic             chord_nxt;
   logic             next_rise;

   assign raw = {raw_slower, raw_faster, raw_next};

   // ---- stage p0/p1: two-flop synchronizer -----------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   // ---- debounce: level follows sync_p1 after a full run of disagreement ----
   always_comb begin
      for (int b = 0; b < 3; b++) begin
         level_nxt[b]  = level[b];
         db_cnt_nxt[b] = '0;
         if (sync_p1[b] != level[b]) begin
            if (db_cnt[b] == DB_LAST) begin
               level_nxt[b] = ~level[b];
            end else begin
               db_cnt_nxt[b] = db_cnt[b] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level <= '0;
         for (int b = 0; b < 3; b++) begin
            db_cnt[b] <= '0;
         end
      end else begin
         level <= level_nxt;
         for (int b = 0; b < 3; b++) begin
            db_cnt[b] <= db_cnt_nxt[b];
         end
      end
   end

   assign btn_level = level;

   // Pulses react to the level the debouncer is about to take, so the pulse
   // register loads on the same edge the level flips.
   assign next_rise = level_nxt[0] & ~level[0];
   assign chord_nxt = level_nxt[1] & level_nxt[2];

   // ---- repeat FSMs for faster/slower ---------------------------------------
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rep_state_nxt[i] = rep_state[i];
         hold_cnt_nxt[i]  = '0;
         rep_pulse[i]     = 1'b0;
         if (!level_nxt[i+1]) begin
            // Release (or never pressed): drop back quietly.
            rep_state_nxt[i] = IDLE;
         end else if (chord_nxt) begin
            // Chord: park both channels in HOLD with timing frozen at zero,
            // including the rise that creates the chord.
            rep_state_nxt[i] = HOLD;
         end else begin
            unique case (rep_state[i])
               IDLE: begin
                  // Only reachable with level_nxt high on a rise.
                  rep_state_nxt[i] = HOLD;
                  rep_pulse[i]     = 1'b1;
               end
               HOLD: begin
                  if (chord) begin
                     // First edge after the chord ends: restart timing, no pulse.
                     hold_cnt_nxt[i] = '0;
                  end else if (REPEAT_EN != 0) begin
                     if (hold_cnt[i] == DELAY_LAST) begin
                        rep_pulse[i]     = 1'b1;
                        rep_state_nxt[i] = REPEAT;
                     end else begin
                        hold_cnt_nxt[i] = hold_cnt[i] + CNT_W'(1);
                     end
                  end
               end
               REPEAT: begin
                  if (hold_cnt[i] == PERIOD_LAST) begin
                     rep_pulse[i] = 1'b1;
                  end else begin
                     hold_cnt_nxt[i] = hold_cnt[i] + CNT_W'(1);
                  end
               end
               default: begin
                  rep_state_nxt[i] = IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chord <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            rep_state[i] <= IDLE;
            hold_cnt[i]  <= '0;
         end
      end else begin
         chord <= chord_nxt;
         for (int i = 0; i < 2; i++) begin
            rep_state[i] <= rep_state_nxt[i];
            hold_cnt[i]  <= hold_cnt_nxt[i];
         end
      end
   end

   // ---- output pulse registers ----------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         next   <= 1'b0;
         faster <= 1'b0;
         slower <= 1'b0;
      end else begin
         next   <= next_rise;
         faster <= rep_pulse[0];
         slower <= rep_pulse[1];
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Two instances share one stimulus: dut_rep (auto-repeat on) and dut_one
// (auto-repeat off). A behavioural model derives the debounced levels from a
// window of recent synchronized samples and the repeat pulses from the time
// elapsed since each press (or chord exit); every cycle both DUTs are compared
// to it. Directed scenarios then check pulse edge lists against hand-computed
// literal values.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic clk;
   logic reset;
   logic raw_next;
   logic raw_faster;
   logic raw_slower;

   logic       next_r, faster_r, slower_r;
   logic [2:0] level_r;
   logic       next_o, faster_o, slower_o;
   logic [2:0] level_o;

   button_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP),
      .REPEAT_EN      (1)
   ) dut_rep (
      .clk       (clk),
      .reset     (reset),
      .raw_next  (raw_next),
      .raw_faster(raw_faster),
      .raw_slower(raw_slower),
      .next      (next_r),
      .faster    (faster_r),
      .slower    (slower_r),
      .btn_level (level_r)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP),
      .REPEAT_EN      (0)
   ) dut_one (
      .clk       (clk),
      .reset     (reset),
      .raw_next  (raw_next),
      .raw_faster(raw_faster),
      .raw_slower(raw_slower),
      .next      (next_o),
      .faster    (faster_o),
      .slower    (slower_o),
      .btn_level (level_o)
   );

   int vectors = 0;
   int errors  = 0;

   // Edge bookkeeping and input samples taken at each rising edge.
   int         edge_cnt = 0;
   logic [2:0] smp_raw  = '0;
   logic       smp_rst  = 1'b0;

   // Model state.
   bit [2:0] r1, r2;
   bit       win [3][D];
   bit [2:0] lvl;
   int       start [2];
   bit       exp_next;
   bit       exp_rep [2];
   bit       exp_one [2];

   // Observed pulse edges (absolute edge numbers).
   int q_next_r[$], q_fast_r[$], q_slow_r[$];
   int q_next_o[$], q_fast_o[$], q_slow_o[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         edge_cnt = edge_cnt + 1;
         smp_raw  = {raw_slower, raw_faster, raw_next};
         smp_rst  = reset;
      end
   end

   task automatic check1(input string name, input int actual, input int expected);
      vectors = vectors + 1;
      if (actual != expected) begin
         errors = errors + 1;
         $display("FAIL %s @edge %0d: got %0d, required %0d", name, edge_cnt, actual, expected);
      end
   endtask

   task automatic model_clear();
      r1  = '0;
      r2  = '0;
      lvl = '0;
      for (int b = 0; b < 3; b++)
         for (int k = 0; k < D; k++)
            win[b][k] = 1'b0;
      start[0]   = -1;
      start[1]   = -1;
      exp_next   = 1'b0;
      exp_rep[0] = 1'b0;
      exp_rep[1] = 1'b0;
      exp_one[0] = 1'b0;
      exp_one[1] = 1'b0;
   endtask

   // One rising edge t: the value the debouncer sees is the raw sample from
   // two edges earlier; the level flips when the last D such values all
   // disagree with it.
   task automatic model_step(input int t);
      bit       used;
      bit       all_diff;
      bit       chord;
      bit [2:0] prev;
      int       h;
      for (int b = 0; b < 3; b++) begin
         used  = r2[b];
         r2[b] = r1[b];
         r1[b] = smp_raw[b];
         for (int k = D - 1; k > 0; k--) win[b][k] = win[b][k-1];
         win[b][0] = used;
         all_diff = 1'b1;
         for (int k = 0; k < D; k++)
            if (win[b][k] == lvl[b]) all_diff = 1'b0;
         prev[b] = lvl[b];
         if (all_diff) lvl[b] = ~lvl[b];
      end
      exp_next = lvl[0] && !prev[0];
      chord    = lvl[1] && lvl[2];
      for (int i = 0; i < 2; i++) begin
         exp_rep[i] = 1'b0;
         exp_one[i] = 1'b0;
         if (!lvl[i+1] || chord) begin
            start[i] = -1;
         end else if (!prev[i+1]) begin
            start[i]   = t;
            exp_rep[i] = 1'b1;
            exp_one[i] = 1'b1;
         end else if (start[i] < 0) begin
            start[i] = t;
         end else begin
            h = t - start[i];
            exp_rep[i] = (h >= RD) && (((h - RD) % RP) == 0);
         end
      end
   endtask

   // Per-cycle compare, sampled on the falling edge.
   initial begin
      model_clear();
      forever begin
         @(negedge clk);
         if (!reset || !smp_rst) model_clear();
         else model_step(edge_cnt);
         check1("rep.next",   next_r,   exp_next);
         check1("rep.faster", faster_r, exp_rep[0]);
         check1("rep.slower", slower_r, exp_rep[1]);
         check1("rep.level",  level_r,  lvl);
         check1("one.next",   next_o,   exp_next);
         check1("one.faster", faster_o, exp_one[0]);
         check1("one.slower", slower_o, exp_one[1]);
         check1("one.level",  level_o,  lvl);
         if (next_r)   q_next_r.push_back(edge_cnt);
         if (faster_r) q_fast_r.push_back(edge_cnt);
         if (slower_r) q_slow_r.push_back(edge_cnt);
         if (next_o)   q_next_o.push_back(edge_cnt);
         if (faster_o) q_fast_o.push_back(edge_cnt);
         if (slower_o) q_slow_o.push_back(edge_cnt);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic start_scn(output int base);
      q_next_r.delete(); q_fast_r.delete(); q_slow_r.delete();
      q_next_o.delete(); q_fast_o.delete(); q_slow_o.delete();
      base = edge_cnt + 1;
   endtask

   task automatic check_pulses(input string name, input int got[$], input int base,
                               input int want[$]);
      bit ok;
      int bad;
      ok  = (got.size() == want.size());
      bad = -1;
      if (ok) begin
         for (int i = 0; i < want.size(); i++) begin
            if (got[i] - base != want[i]) begin
               ok = 1'b0;
               if (bad < 0) bad = i;
            end
         end
      end
      vectors = vectors + 1;
      if (!ok) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d pulses (first rel edge %0d, idx %0d), required %0d pulses (first rel edge %0d)",
                  name, got.size(), (got.size() > 0) ? got[0] - base : -1, bad,
                  want.size(), (want.size() > 0) ? want[0] : -1);
      end
   endtask

   initial begin
      int base;
      int none[$];
      int w[$];
      bit pat [10];

      reset      = 1'b0;
      raw_next   = 1'b0;
      raw_faster = 1'b0;
      raw_slower = 1'b0;
      none.delete();
      tick(5);
      check1("reset.level", level_r, 0);
      check1("reset.next",  next_r,  0);
      reset = 1'b1;
      tick(5);

      // Clean press on next.
      start_scn(base);
      raw_next = 1'b1;
      tick(100);
      raw_next = 0;
      tick(20);
      w = '{5};
      check_pulses("clean.next", q_next_r, base, w);
      check_pulses("clean.faster", q_fast_r, base, none);

      // Short glitch on next never propagates.
      start_scn(base);
      raw_next = 1'b1;
      tick(3);
      raw_next = 1'b0;
      tick(12);
      check_pulses("glitch.next", q_next_r, base, none);

      // Bounce on faster; released before the first repeat.
      start_scn(base);
      pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
      for (int k = 0; k < 10; k++) begin
         raw_faster = pat[k];
         tick(1);
      end
      tick(10);
      raw_faster = 1'b0;
      tick(20);
      w = '{10};
      check_pulses("bounce.faster.rep", q_fast_r, base, w);
      check_pulses("bounce.faster.one", q_fast_o, base, w);

      // Auto-repeat on slower.
      start_scn(base);
      raw_slower = 1'b1;
      tick(100);
      raw_slower = 1'b0;
      tick(20);
      w = '{5, 25, 33, 41, 49, 57, 65, 73, 81, 89, 97};
      check_pulses("repeat.slower.rep", q_slow_r, base, w);
      w = '{5};
      check_pulses("repeat.slower.one", q_slow_o, base, w);

      // Chord: faster held, slower joins at 10, leaves at 40.
      start_scn(base);
      raw_faster = 1'b1;
      tick(10);
      raw_slower = 1'b1;
      tick(30);
      raw_slower = 1'b0;
      tick(50);
      raw_faster = 1'b0;
      tick(20);
      w = '{5, 65, 73, 81, 89};
      check_pulses("chord.faster.rep", q_fast_r, base, w);
      check_pulses("chord.slower.rep", q_slow_r, base, none);
      w = '{5};
      check_pulses("chord.faster.one", q_fast_o, base, w);

      // Reset in the middle of a debounce.
      start_scn(base);
      raw_next = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(2);
      check1("midreset.level", level_r, 0);
      tick(5);
      reset = 1'b1;
      tick(20);
      raw_next = 1'b0;
      tick(20);
      w = '{15};
      check_pulses("midreset.next", q_next_r, base, w);

      // Faster held long: repeat vs. single pulse.
      start_scn(base);
      raw_faster = 1'b1;
      tick(100);
      raw_faster = 1'b0;
      tick(20);
      w = '{5, 25, 33, 41, 49, 57, 65, 73, 81, 89, 97};
      check_pulses("hold.faster.rep", q_fast_r, base, w);
      w = '{5};
      check_pulses("hold.faster.one", q_fast_o, base, w);

      // next and faster together pulse on the same cycle.
      start_scn(base);
      raw_next   = 1'b1;
      raw_faster = 1'b1;
      tick(12);
      raw_next   = 1'b0;
      raw_faster = 1'b0;
      tick(15);
      w = '{5};
      check_pulses("simul.next", q_next_r, base, w);
      check_pulses("simul.faster", q_fast_r, base, w);

      // faster and slower together form a chord from the start: no pulses.
      start_scn(base);
      raw_faster = 1'b1;
      raw_slower = 1'b1;
      tick(8);
      check1("both.level", level_r, 6);
      tick(4);
      raw_faster = 1'b0;
      raw_slower = 1'b0;
      tick(15);
      check_pulses("both.faster", q_fast_r, base, none);
      check_pulses("both.slower", q_slow_r, base, none);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
